wb_regfile: RTL and testbench



---
 rtl/wb_regfile.sv | 69 ++++++
 tb/tb_wb_regfile.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback end: selects the result, commits it to a 16x16 register file with bypassed reads, tracks halt and retirement.
// Reads and wb_data are combinational; writes, halt and count update on the next edge. There is no backpressure.
module wb_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [15:0] wb_ALU_result,
  input  logic [15:0] wb_memData,
  input  logic [15:0] wb_PC_next,
  input  logic        wb_MemToReg,
  input  logic        wb_PCToReg,
  input  logic        wb_RegWrite,
  input  logic        wb_HLT,
  input  logic [3:0]  wb_DstReg,
  input  logic [3:0]  SrcReg1,
  input  logic [3:0]  SrcReg2,
  output logic [15:0] SrcData1,
  output logic [15:0] SrcData2,
  output logic [15:0] wb_data,
  output logic        halted,
  output logic [15:0] retired_count
);

  // R0 has no storage; it always reads as zero.
  logic [15:0] regFile [1:15];
  logic        writeEn;
  logic        retireEn;

  always_comb begin
    if (wb_PCToReg)       wb_data = wb_PC_next;
    else if (wb_MemToReg) wb_data = wb_memData;
    else                  wb_data = wb_ALU_result;
  end

  assign writeEn  = wb_valid & wb_RegWrite & ~wb_HLT & ~halted & (wb_DstReg != 4'd0);
  assign retireEn = wb_valid & ~halted;

  // A read of the register being written this cycle sees the new value.
  always_comb begin
    if (SrcReg1 == 4'd0)                       SrcData1 = 16'h0000;
    else if (writeEn && SrcReg1 == wb_DstReg)  SrcData1 = wb_data;
    else                                       SrcData1 = regFile[SrcReg1];
  end

  always_comb begin
    if (SrcReg2 == 4'd0)                       SrcData2 = 16'h0000;
    else if (writeEn && SrcReg2 == wb_DstReg)  SrcData2 = wb_data;
    else                                       SrcData2 = regFile[SrcReg2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 16; i++) regFile[i] <= 16'h0000;
    end else if (writeEn) begin
      regFile[wb_DstReg] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted        <= 1'b0;
      retired_count <= 16'h0000;
    end else begin
      if (retireEn && wb_HLT) halted <= 1'b1;
      if (retireEn && retired_count != 16'hFFFF) retired_count <= retired_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: hand-computed expectations checked with immediate assertions.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [15:0] wb_ALU_result;
  logic [15:0] wb_memData;
  logic [15:0] wb_PC_next;
  logic        wb_MemToReg;
  logic        wb_PCToReg;
  logic        wb_RegWrite;
  logic        wb_HLT;
  logic [3:0]  wb_DstReg;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;
  logic [15:0] wb_data;
  logic        halted;
  logic [15:0] retired_count;

  int checks = 0;
  int failures = 0;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ALU_result(wb_ALU_result),
    .wb_memData(wb_memData), .wb_PC_next(wb_PC_next), .wb_MemToReg(wb_MemToReg),
    .wb_PCToReg(wb_PCToReg), .wb_RegWrite(wb_RegWrite), .wb_HLT(wb_HLT),
    .wb_DstReg(wb_DstReg), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2), .SrcData1(SrcData1),
    .SrcData2(SrcData2), .wb_data(wb_data), .halted(halted), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] mem,
                       input logic [15:0] pc, input logic m2r, input logic p2r,
                       input logic rw, input logic hlt, input logic [3:0] dst);
    wb_valid = v; wb_ALU_result = alu; wb_memData = mem; wb_PC_next = pc;
    wb_MemToReg = m2r; wb_PCToReg = p2r; wb_RegWrite = rw; wb_HLT = hlt; wb_DstReg = dst;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
    SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    #12 rst_n = 1'b1;

    // Reset state: every index reads zero.
    #1;
    chk("rst_halted", {15'd0, halted}, 16'h0000);
    chk("rst_count", retired_count, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      SrcReg1 = 4'(i); SrcReg2 = 4'(15 - i);
      #1;
      chk($sformatf("rst_rd1_r%0d", i), SrcData1, 16'h0000);
      chk($sformatf("rst_rd2_r%0d", 15 - i), SrcData2, 16'h0000);
    end

    // ALU write R5 with same-cycle bypass on both ports.
    drive(1, 16'h1234, 16'h0BAD, 16'h0C0D, 0, 0, 1, 0, 4'd5);
    SrcReg1 = 4'd5; SrcReg2 = 4'd5;
    #1;
    chk("alu_wbdata", wb_data, 16'h1234);
    chk("byp_rd1", SrcData1, 16'h1234);
    chk("byp_rd2", SrcData2, 16'h1234);
    cycle();
    // Bubble with a would-be write must change nothing.
    drive(0, 16'h9999, 16'h0, 16'h0, 0, 0, 1, 0, 4'd5);
    #1;
    chk("bubble_wbdata", wb_data, 16'h9999);
    chk("r5_rd1", SrcData1, 16'h1234);
    chk("r5_rd2", SrcData2, 16'h1234);
    chk("count_1", retired_count, 16'd1);
    cycle();
    chk("bubble_nowrite", SrcData1, 16'h1234);
    chk("bubble_nocount", retired_count, 16'd1);

    // Select priority: PC over memory over ALU.
    drive(1, 16'h1111, 16'hBEEF, 16'h0042, 1, 1, 1, 0, 4'd3);
    #1;
    chk("prio_pc", wb_data, 16'h0042);
    cycle();
    drive(1, 16'h1111, 16'hBEEF, 16'h0042, 1, 0, 1, 0, 4'd4);
    #1;
    chk("prio_mem", wb_data, 16'hBEEF);
    cycle();
    drive(0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
    SrcReg1 = 4'd3; SrcReg2 = 4'd4;
    #1;
    chk("r3_pc", SrcData1, 16'h0042);
    chk("r4_mem", SrcData2, 16'hBEEF);
    chk("count_3", retired_count, 16'd3);

    // R0 write attempt: no storage, no bypass, still retires.
    drive(1, 16'hFFFF, 16'h0, 16'h0, 0, 0, 1, 0, 4'd0);
    SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    #1;
    chk("r0_wbdata", wb_data, 16'hFFFF);
    chk("r0_nobyp1", SrcData1, 16'h0000);
    chk("r0_nobyp2", SrcData2, 16'h0000);
    cycle();
    drive(0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
    #1;
    chk("r0_zero", SrcData1, 16'h0000);
    chk("count_4", retired_count, 16'd4);

    // Seed R7 and R2, then HLT targeting R7.
    drive(1, 16'h7777, 16'h0, 16'h0, 0, 0, 1, 0, 4'd7);
    cycle();
    drive(1, 16'hAAAA, 16'h0, 16'h0, 0, 0, 1, 0, 4'd2);
    cycle();
    drive(1, 16'hDEAD, 16'h0, 16'h0, 0, 0, 1, 1, 4'd7);
    SrcReg1 = 4'd7; SrcReg2 = 4'd2;
    #1;
    chk("hlt_nobyp", SrcData1, 16'h7777);
    chk("r2_aaaa", SrcData2, 16'hAAAA);
    chk("pre_halt", {15'd0, halted}, 16'h0000);
    cycle();
    chk("halted_set", {15'd0, halted}, 16'h0001);
    chk("count_hlt", retired_count, 16'd7);
    drive(1, 16'h5555, 16'h0, 16'h0, 0, 0, 1, 0, 4'd8);
    SrcReg1 = 4'd8;
    #1;
    chk("halt_nobyp", SrcData1, 16'h0000);
    cycle();
    drive(0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
    SrcReg2 = 4'd7;
    #1;
    chk("halt_nowrite", SrcData1, 16'h0000);
    chk("r7_kept", SrcData2, 16'h7777);
    chk("count_frozen", retired_count, 16'd7);
    chk("halt_sticky", {15'd0, halted}, 16'h0001);

    // Asynchronous reset between edges.
    SrcReg1 = 4'd2;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_r2", SrcData1, 16'h0000);
    chk("arst_r7", SrcData2, 16'h0000);
    chk("arst_halted", {15'd0, halted}, 16'h0000);
    chk("arst_count", retired_count, 16'h0000);
    drive(1, 16'h3333, 16'h0, 16'h0, 0, 0, 1, 0, 4'd9);
    cycle();
    drive(0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
    SrcReg1 = 4'd9;
    #1;
    chk("rst_write_lost", SrcData1, 16'h0000);
    chk("rst_count_held", retired_count, 16'h0000);
    rst_n = 1'b1;
    drive(1, 16'h0001, 16'h0, 16'h0, 0, 0, 1, 0, 4'd2);
    SrcReg1 = 4'd2;
    cycle();
    drive(0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 4'd0);
    #1;
    chk("post_rst_r2", SrcData1, 16'h0001);
    chk("post_rst_count", retired_count, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
